pipe_hazard_ctrl: RTL and testbench

- Generates the stall and flush controls that the ID/EX and IF/ID pipeline registers and the PC consume: PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush.
- Consumes EX-stage control and register addresses fed back from the ID/EX register outputs, plus ID-stage decode fields.
- Resolves three hazard classes: load-use, taken branch/jump, and CSR serialization.
- CSR serialization holds a CSR instruction in ID until the older instructions have drained.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-address
// width and the hazard FSM state encodings.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

package pipe_hazard_ctrl_pkg;

   localparam int ADDR_W = `ADDR_WIDTH;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      RELEASE = 2'd2
   } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of
// a load currently in EX. Purely combinational so a forwarding unit can reuse it.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

module load_use_detect
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [`ADDR_WIDTH-1:0] ID_Rs1_Addr,
   input  logic [`ADDR_WIDTH-1:0] ID_Rs2_Addr,
   input  logic                   ID_Use_Rs1,
   input  logic                   ID_Use_Rs2,
   input  logic                   EX_Mem_r,
   input  logic                   EX_Reg_w,
   input  logic [`ADDR_WIDTH-1:0] EX_Rd_Addr,
   output logic                   load_use
);

   logic rs1_hit;
   logic rs2_hit;
   logic rd_live;

   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   assign rd_live  = EX_Mem_r & EX_Reg_w & (EX_Rd_Addr != '0);
   assign rs1_hit  = ID_Use_Rs1 & (ID_Rs1_Addr == EX_Rd_Addr);
   assign rs2_hit  = ID_Use_Rs2 & (ID_Rs2_Addr == EX_Rd_Addr);
   assign load_use = rd_live & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: produces PC/IF-ID stall and IF-ID/ID-EX flush
// controls for load-use, redirect and CSR serialization hazards.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   RUN     | normal flow; load-use stalls for one cycle; CSR starts drain
//   DRAIN   | CSR held in ID while bubbles go into EX
//   RELEASE | one free cycle so the CSR advances into EX
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_WIDTH    = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [`ADDR_WIDTH-1:0] ID_Rs1_Addr,
   input  logic [`ADDR_WIDTH-1:0] ID_Rs2_Addr,
   input  logic                   ID_Use_Rs1,
   input  logic                   ID_Use_Rs2,
   input  logic                   ID_CSR_en,
   input  logic                   EX_Mem_r,
   input  logic                   EX_Reg_w,
   input  logic [`ADDR_WIDTH-1:0] EX_Rd_Addr,
   input  logic                   EX_Redirect,
   output logic                   PC_Stall,
   output logic                   IF_ID_Stall,
   output logic                   IF_ID_Flush,
   output logic                   ID_EX_Flush,
   output logic [31:0]            Stall_Cnt,
   output logic [31:0]            Flush_Cnt
);

   // The RUN cycle that detects the CSR already inserts the first bubble, so
   // the counter covers the remaining DRAIN_CYCLES-1 bubbles spent in DRAIN.
   localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD = CNT_WIDTH'(DRAIN_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

   hz_state_e            state;
   hz_state_e            state_nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic                 load_use;
   logic                 stall;
   logic                 flush_if;
   logic                 flush_ex;

   load_use_detect u_load_use_detect (
      .ID_Rs1_Addr (ID_Rs1_Addr),
      .ID_Rs2_Addr (ID_Rs2_Addr),
      .ID_Use_Rs1  (ID_Use_Rs1),
      .ID_Use_Rs2  (ID_Use_Rs2),
      .EX_Mem_r    (EX_Mem_r),
      .EX_Reg_w    (EX_Reg_w),
      .EX_Rd_Addr  (EX_Rd_Addr),
      .load_use    (load_use)
   );

   // State and drain-counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and hazard controls; redirect beats CSR drain beats load-use
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall     = 1'b0;
      flush_if  = 1'b0;
      flush_ex  = 1'b0;
      if (EX_Redirect) begin
         flush_if  = 1'b1;
         flush_ex  = 1'b1;
         state_nxt = RUN;
         cnt_nxt   = '0;
      end else begin
         case (state)
            RUN: begin
               if (ID_CSR_en) begin
                  stall     = 1'b1;
                  flush_ex  = 1'b1;
                  cnt_nxt   = DRAIN_LOAD;
                  state_nxt = (DRAIN_CYCLES == 1) ? RELEASE : DRAIN;
               end else if (load_use) begin
                  stall    = 1'b1;
                  flush_ex = 1'b1;
               end
            end
            DRAIN: begin
               stall    = 1'b1;
               flush_ex = 1'b1;
               cnt_nxt  = cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state_nxt = RELEASE;
               end
            end
            RELEASE: begin
               state_nxt = RUN;
            end
            default: begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Controls are held quiet while reset is asserted
   always_comb begin
      PC_Stall    = rst_n & stall;
      IF_ID_Stall = rst_n & stall;
      IF_ID_Flush = rst_n & flush_if;
      ID_EX_Flush = rst_n & flush_ex;
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   // Free-running event counters, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (PC_Stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (EX_Redirect) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign Stall_Cnt = stall_cnt_q;
   assign Flush_Cnt = flush_cnt_q;
`else
   assign Stall_Cnt = '0;
   assign Flush_Cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl (DRAIN_CYCLES=3). Checks the counter ports
// against a model when HAZARD_PERF_EN is defined, otherwise against zero.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   typedef struct {
      logic              rst_n;
      logic [ADDR_W-1:0] rs1;
      logic [ADDR_W-1:0] rs2;
      logic              use1;
      logic              use2;
      logic              csr;
      logic              mem_r;
      logic              reg_w;
      logic [ADDR_W-1:0] rd;
      logic              redir;
      logic [3:0]        exp;   // {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush}
      string             name;
   } vec_t;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] stall_cnt;
      logic [31:0] flush_cnt;
      string       name;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] ID_Rs1_Addr, ID_Rs2_Addr, EX_Rd_Addr;
   logic              ID_Use_Rs1, ID_Use_Rs2, ID_CSR_en;
   logic              EX_Mem_r, EX_Reg_w, EX_Redirect;
   logic              PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush;
   logic [31:0]       Stall_Cnt, Flush_Cnt;

   int   n_cmp = 0;
   int   n_err = 0;
   vec_t vq[$];
   exp_t sb[$];
   logic [31:0] m_stall = 0;
   logic [31:0] m_flush = 0;

   pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_WIDTH(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ID_Rs1_Addr (ID_Rs1_Addr),
      .ID_Rs2_Addr (ID_Rs2_Addr),
      .ID_Use_Rs1  (ID_Use_Rs1),
      .ID_Use_Rs2  (ID_Use_Rs2),
      .ID_CSR_en   (ID_CSR_en),
      .EX_Mem_r    (EX_Mem_r),
      .EX_Reg_w    (EX_Reg_w),
      .EX_Rd_Addr  (EX_Rd_Addr),
      .EX_Redirect (EX_Redirect),
      .PC_Stall    (PC_Stall),
      .IF_ID_Stall (IF_ID_Stall),
      .IF_ID_Flush (IF_ID_Flush),
      .ID_EX_Flush (ID_EX_Flush),
      .Stall_Cnt   (Stall_Cnt),
      .Flush_Cnt   (Flush_Cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic add(input logic r, input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                      input logic u1, input logic u2, input logic csr, input logic mr, input logic rw,
                      input logic [ADDR_W-1:0] rd, input logic redir, input logic [3:0] exp,
                      input string name);
      vec_t v;
      v.rst_n = r; v.rs1 = rs1; v.rs2 = rs2; v.use1 = u1; v.use2 = u2; v.csr = csr;
      v.mem_r = mr; v.reg_w = rw; v.rd = rd; v.redir = redir; v.exp = exp; v.name = name;
      vq.push_back(v);
   endtask

   // Drive one cycle of stimulus, push its expectation, then check mid-cycle
   task automatic apply(input vec_t v);
      exp_t e, got;
      @(negedge clk);
      rst_n = v.rst_n; ID_Rs1_Addr = v.rs1; ID_Rs2_Addr = v.rs2;
      ID_Use_Rs1 = v.use1; ID_Use_Rs2 = v.use2; ID_CSR_en = v.csr;
      EX_Mem_r = v.mem_r; EX_Reg_w = v.reg_w; EX_Rd_Addr = v.rd; EX_Redirect = v.redir;
      e.ctrl = v.exp; e.name = v.name;
`ifdef HAZARD_PERF_EN
      e.stall_cnt = m_stall; e.flush_cnt = m_flush;
`else
      e.stall_cnt = 32'd0; e.flush_cnt = 32'd0;
`endif
      sb.push_back(e);
      #1;
      got = sb.pop_front();
      n_cmp++;
      if ({PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush} !== got.ctrl) begin
         n_err++;
         $display("FAIL %s ctrl: got %b want %b", got.name,
                  {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush}, got.ctrl);
      end
      n_cmp++;
      if (Stall_Cnt !== got.stall_cnt) begin
         n_err++;
         $display("FAIL %s stall_cnt: got %0d want %0d", got.name, Stall_Cnt, got.stall_cnt);
      end
      n_cmp++;
      if (Flush_Cnt !== got.flush_cnt) begin
         n_err++;
         $display("FAIL %s flush_cnt: got %0d want %0d", got.name, Flush_Cnt, got.flush_cnt);
      end
      @(posedge clk);
      if (!v.rst_n) begin
         m_stall = 0;
         m_flush = 0;
      end else begin
         m_stall = m_stall + 32'(v.exp[3]);
         m_flush = m_flush + 32'(v.redir);
      end
   endtask

   task automatic run_queue();
      while (vq.size() > 0) apply(vq.pop_front());
   endtask

   initial begin
      rst_n = 1'b0; ID_Rs1_Addr = '0; ID_Rs2_Addr = '0; ID_Use_Rs1 = 1'b0; ID_Use_Rs2 = 1'b0;
      ID_CSR_en = 1'b0; EX_Mem_r = 1'b0; EX_Reg_w = 1'b0; EX_Rd_Addr = '0; EX_Redirect = 1'b0;

      //   rst rs1 rs2 u1 u2 csr mr rw rd redir exp
      add(0, 0, 5, 0, 1, 0, 1, 1, 5, 0, 4'b0000, "reset_masks_load_use");
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, "reset_masks_redirect");
      add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0000, "reset_masks_csr");
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "idle");
      add(1, 0, 5, 0, 1, 0, 1, 1, 5, 0, 4'b1101, "load_use_rs2");
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "load_use_clears");
      add(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 4'b0000, "x0_no_stall");
      add(1, 7, 0, 1, 0, 0, 1, 1, 7, 0, 4'b1101, "load_use_rs1");
      add(1, 7, 0, 0, 0, 0, 1, 1, 7, 0, 4'b0000, "rs1_not_used");
      add(1, 7, 0, 1, 0, 0, 0, 1, 7, 0, 4'b0000, "not_a_load");
      add(1, 7, 0, 1, 0, 0, 1, 0, 7, 0, 4'b0000, "load_no_write");
      add(1, 3, 4, 1, 1, 0, 1, 1, 7, 0, 4'b0000, "addr_mismatch");
      add(1, 9, 9, 1, 1, 0, 1, 1, 9, 0, 4'b1101, "both_rs_match");
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0011, "redirect");
      add(1, 0, 5, 0, 1, 0, 1, 1, 5, 1, 4'b0011, "redirect_over_load_use");
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 4'b0011, "redirect_over_csr");
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "after_redirect_idle");
      run_queue();

      // CSR held: three bubbles, one RELEASE cycle (load-use ignored there), then a second CSR drains again
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1101, "csr_bubble1");
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1101, "csr_bubble2");
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1101, "csr_bubble3");
      add(1, 0, 5, 0, 1, 1, 1, 1, 5, 0, 4'b0000, "csr_release");
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1101, "csr2_bubble1");
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1101, "csr2_bubble2");
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1101, "csr2_bubble3");
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0000, "csr2_release");
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "csr_done_idle");
      run_queue();

      // Redirect on the second drain bubble squashes the held CSR
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1101, "sq_bubble1");
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 4'b0011, "sq_redirect");
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "sq_back_to_run");
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "sq_idle");
      run_queue();

      // Reset for one edge in the middle of a drain
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1101, "rst_bubble1");
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1101, "rst_bubble2");
      add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0000, "rst_mid_drain");
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "rst_no_residual");
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "rst_idle");
      run_queue();

      // Counter scenario from a clean reset: 1 load-use, one CSR drain, 2 redirects
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "perf_reset");
      add(1, 0, 5, 0, 1, 0, 1, 1, 5, 0, 4'b1101, "perf_load_use");
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1101, "perf_csr1");
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1101, "perf_csr2");
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1101, "perf_csr3");
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "perf_release");
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0011, "perf_redirect1");
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0011, "perf_redirect2");
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "perf_final");
      run_queue();

`ifdef HAZARD_PERF_EN
      n_cmp++;
      if (Stall_Cnt !== 32'd4 || Flush_Cnt !== 32'd2) begin
         n_err++;
         $display("FAIL perf_totals: got stall=%0d flush=%0d want stall=4 flush=2", Stall_Cnt, Flush_Cnt);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
